bf16_op_scheduler: RTL and testbench
====================================

BF16_OP_SCHEDULER -- requirements
Module: bf16_op_scheduler

Interface
REQ-001 The module SHALL have parameter LAT, default 1, meaning cycles from issue to result capture; legal range 1..15.
REQ-002 The module SHALL have port clk, input, 1, the single clock.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port req_valid_i, input, 2, per-requester request valid; index 0 is requester 0.
REQ-005 The module SHALL have port req_ready_o, output, 2, per-requester request accept.
REQ-006 The module SHALL have port req_op_i, input, 2xMODE_WIDTH, per-requester operation code.
REQ-007 The module SHALL have port req_in1_i, input, 2x16, per-requester bf16 operand 1.
REQ-008 The module SHALL have port req_in2_i, input, 2x16, per-requester bf16 operand 2.
REQ-009 The module SHALL have port rsp_valid_o, output, 2, per-requester result valid, at most one bit set.
REQ-010 The module SHALL have port rsp_ready_i, input, 2, per-requester result accept.
REQ-011 The module SHALL have port rsp_data_o, output, 16, bf16 result (shared).
REQ-012 The module SHALL have port rsp_overflow_o, output, 1, result overflow flag.
REQ-013 The module SHALL have port rsp_err_o, output, 1, illegal-opcode flag.
REQ-014 The module SHALL have port dp_op_o, output, MODE_WIDTH, opcode to datapath mux.
REQ-015 The module SHALL have port dp_in1_o, output, 16, datapath operand 1.
REQ-016 The module SHALL have port dp_in2_o, output, 16, datapath operand 2.
REQ-017 The module SHALL have port dp_out_i, input, 16, datapath result.
REQ-018 The module SHALL have port dp_overflow_i, input, 1, datapath overflow.
REQ-019 The module SHALL have port busy_o, output, 1, high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP.
REQ-021 In IDLE, req_ready_o SHALL be asserted for exactly the granted requester; handshake = valid & ready in the same cycle.
REQ-022 Arbitration SHALL be round-robin: when both are valid, grant goes to the requester not served last; a single valid requester SHALL be granted immediately.
REQ-023 On accept, op/in1/in2 SHALL be registered into dp_op_o/dp_in1_o/dp_in2_o, the served index SHALL be stored, and the FSM SHALL go to EXEC with the latency counter loaded to LAT-1.
REQ-024 In EXEC, the counter SHALL decrement each cycle; at zero, dp_out_i/dp_overflow_i SHALL be captured into the response registers and the FSM SHALL go to RESP.
REQ-025 With LAT=1, issue-to-rsp_valid SHALL be exactly 2 cycles after the accept edge.
REQ-026 If opcode is neither MODE_ADD nor MODE_MUL, the module SHALL still run EXEC and RESP, respond rsp_data_o=16'h0, rsp_overflow_o=0, rsp_err_o=1; otherwise rsp_err_o=0.
REQ-027 In RESP, rsp_valid_o[served] SHALL stay high with stable data until rsp_ready_i[served]=1, then the FSM SHALL return to IDLE.
REQ-028 rsp_ready_i of the non-served requester SHALL be ignored.
REQ-029 No new request SHALL be accepted outside IDLE (req_ready_o=0); back-to-back throughput is one op per LAT+2 cycles minimum.
REQ-030 dp_op_o/dp_in1_o/dp_in2_o SHALL hold their values through EXEC and RESP; in IDLE operands SHALL be driven 16'h0.
REQ-031 The round-robin pointer SHALL update only on an accept.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE, rr pointer SHALL favour requester 0, and all outputs SHALL be 0: req_ready_o, rsp_valid_o, rsp_data_o, rsp_overflow_o, rsp_err_o, dp_*_o, busy_o (req_ready_o may rise combinationally after release).
REQ-033 Reset in EXEC or RESP SHALL drop the in-flight op without a response.

Structure
REQ-034 MODE_WIDTH, MODE_ADD and MODE_MUL SHALL come from data_type_pkg; the FSM state enum SHALL be added there as sched_state_e.
REQ-035 The round-robin arbiter SHALL be a sub-module rr_arb2 (2 requests, 1-hot grant, advance input).
REQ-036 dp_* ports SHALL connect directly to op_mux op_i/in1_i/in2_i/out_o/overflow_o.

Verification
REQ-037 Req0 ADD 0x3F80+0x4000, LAT=1 -> rsp_valid_o=01 two cycles after accept, rsp_data_o=0x4040, overflow 0, err 0.
REQ-038 Req0 and req1 valid same cycle after reset, MUL 0x4000*0x4000 each -> req0 served first, then req1; both data 0x4080.
REQ-039 Both requesters continuously valid for 4 ops -> grants alternate 0,1,0,1.
REQ-040 rsp_ready_i held 0 for 5 cycles in RESP -> rsp_valid_o and data stable, req_ready_o=00, busy_o=1.
REQ-041 Illegal opcode from req1 -> rsp_valid_o=10, data 0x0000, rsp_err_o=1.
REQ-042 rst asserted mid-EXEC with LAT=4 -> all outputs 0 immediately, no response issued, next req0 op completes normally.

Source files
------------

// File: rtl/data_type_pkg.sv
// Shared types for the bf16 op scheduler: opcode encodings and scheduler FSM states.
package data_type_pkg;

   localparam int MODE_WIDTH = 2;
   localparam logic [MODE_WIDTH-1:0] MODE_ADD = 2'd0;
   localparam logic [MODE_WIDTH-1:0] MODE_MUL = 2'd1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } sched_state_e;

   function automatic logic mode_legal(input logic [MODE_WIDTH-1:0] op);
      return (op == MODE_ADD) || (op == MODE_MUL);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer moves only when advance_i
// reports that the current grant was taken.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   // prio_q=0 favours requester 0 on a tie, prio_q=1 favours requester 1
   logic prio_q, prio_d;

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) gnt_o = prio_q ? 2'b10 : 2'b01;
   end

   always_comb begin
      prio_d = prio_q;
      if (advance_i) prio_d = gnt_o[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prio_q <= 1'b0;
      else     prio_q <= prio_d;
   end

endmodule

// File: rtl/bf16_op_scheduler.sv
// Schedules bf16 ops from two requesters onto a shared op_mux datapath:
// arbitrate in IDLE, wait LAT cycles in EXEC, hold the result in RESP until taken.
module bf16_op_scheduler
   import data_type_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0][MODE_WIDTH-1:0] req_op_i,
   input  logic [1:0][15:0]           req_in1_i,
   input  logic [1:0][15:0]           req_in2_i,
   output logic [1:0]                 rsp_valid_o,
   input  logic [1:0]                 rsp_ready_i,
   output logic [15:0]                rsp_data_o,
   output logic                       rsp_overflow_o,
   output logic                       rsp_err_o,
   output logic [MODE_WIDTH-1:0]      dp_op_o,
   output logic [15:0]                dp_in1_o,
   output logic [15:0]                dp_in2_o,
   input  logic [15:0]                dp_out_i,
   input  logic                       dp_overflow_i,
   output logic                       busy_o
);

   sched_state_e          state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [MODE_WIDTH-1:0] op_q, op_d;
   logic [15:0]           in1_q, in1_d, in2_q, in2_d;
   logic                  idx_q, idx_d;
   logic [15:0]           data_q, data_d;
   logic                  ovf_q, ovf_d, err_q, err_d;
   logic [1:0]            gnt;
   logic                  accept, sel, legal;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_valid_i),
      .advance_i(accept),
      .gnt_o    (gnt)
   );

   // Gated by rst so ready stays low while reset is held, even though the FSM reads IDLE.
   assign req_ready_o = (state_q == IDLE && !rst) ? gnt : 2'b00;
   assign accept      = |(req_valid_i & req_ready_o);
   assign sel         = gnt[1];
   assign legal       = mode_legal(op_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      idx_d   = idx_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_d    = req_op_i[sel];
               in1_d   = req_in1_i[sel];
               in2_d   = req_in2_i[sel];
               idx_d   = sel;
               cnt_d   = 4'(LAT - 1);
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               // Illegal opcodes still take the full latency but return a clean zero result.
               data_d  = legal ? dp_out_i : 16'h0000;
               ovf_d   = legal & dp_overflow_i;
               err_d   = !legal;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready_i[idx_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= '0;
         in1_q   <= 16'h0000;
         in2_q   <= 16'h0000;
         idx_q   <= 1'b0;
         data_q  <= 16'h0000;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign busy_o         = (state_q != IDLE);
   assign rsp_valid_o    = (state_q == RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data_o     = data_q;
   assign rsp_overflow_o = ovf_q;
   assign rsp_err_o      = err_q;
   assign dp_op_o        = busy_o ? op_q  : '0;
   assign dp_in1_o       = busy_o ? in1_q : 16'h0000;
   assign dp_in2_o       = busy_o ? in2_q : 16'h0000;

endmodule

// File: tb/tb_bf16_op_scheduler.sv
// Scoreboard bench for bf16_op_scheduler: a LAT=1 instance for the main scenarios and a
// LAT=4 instance for reset during EXEC; a small op_mux stand-in feeds both datapaths.
module tb_bf16_op_scheduler;
   import data_type_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  idx;
      logic [15:0] data;
      logic        ovf;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int pass_n  = 0;
   int total_n = 0;

   // op_mux stand-in: true bf16 results for the operand pairs used, arbitrary otherwise;
   // illegal opcodes produce junk that the scheduler must suppress.
   function automatic logic [16:0] dp_model(input logic [MODE_WIDTH-1:0] op, input logic [15:0] a, input logic [15:0] b);
      if (op == MODE_ADD) begin
         if (a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
         if (a == 16'h3F80 && b == 16'h3F80) return {1'b0, 16'h4000};
         return {1'b0, a ^ b};
      end
      if (op == MODE_MUL) begin
         if (a == 16'h4000 && b == 16'h4000) return {1'b0, 16'h4080};
         if (a == 16'h3F80 && b == 16'h4040) return {1'b0, 16'h4040};
         if (a == 16'h7F00 && b == 16'h7F00) return {1'b1, 16'h7F80};
         return {1'b0, a + b};
      end
      return {1'b1, 16'hDEAD};
   endfunction

   function automatic exp_t expect_rsp(input logic [1:0] idx, input logic [MODE_WIDTH-1:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      logic [16:0] r;
      r     = dp_model(op, a, b);
      e.idx = idx;
      e.err = !(op == MODE_ADD || op == MODE_MUL);
      e.data = e.err ? 16'h0000 : r[15:0];
      e.ovf  = e.err ? 1'b0 : r[16];
      return e;
   endfunction

   // LAT=1 instance
   logic [1:0] rv = '0, rrdy, sv, srdy = '0;
   logic [1:0][MODE_WIDTH-1:0] rop = '0;
   logic [1:0][15:0] ra = '0, rb = '0;
   logic [15:0] sdata, din1, din2, dout;
   logic sovf, serr, dovf, busy;
   logic [MODE_WIDTH-1:0] dop;
   assign {dovf, dout} = dp_model(dop, din1, din2);

   bf16_op_scheduler #(.LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(rv), .req_ready_o(rrdy), .req_op_i(rop), .req_in1_i(ra), .req_in2_i(rb),
      .rsp_valid_o(sv), .rsp_ready_i(srdy), .rsp_data_o(sdata), .rsp_overflow_o(sovf), .rsp_err_o(serr),
      .dp_op_o(dop), .dp_in1_o(din1), .dp_in2_o(din2), .dp_out_i(dout), .dp_overflow_i(dovf),
      .busy_o(busy)
   );

   // LAT=4 instance
   logic [1:0] b_rv = '0, b_rrdy, b_sv, b_srdy = '0;
   logic [1:0][MODE_WIDTH-1:0] b_rop = '0;
   logic [1:0][15:0] b_ra = '0, b_rb = '0;
   logic [15:0] b_sdata, b_din1, b_din2, b_dout;
   logic b_sovf, b_serr, b_dovf, b_busy;
   logic [MODE_WIDTH-1:0] b_dop;
   assign {b_dovf, b_dout} = dp_model(b_dop, b_din1, b_din2);

   bf16_op_scheduler #(.LAT(4)) dut4 (
      .clk(clk), .rst(rst),
      .req_valid_i(b_rv), .req_ready_o(b_rrdy), .req_op_i(b_rop), .req_in1_i(b_ra), .req_in2_i(b_rb),
      .rsp_valid_o(b_sv), .rsp_ready_i(b_srdy), .rsp_data_o(b_sdata), .rsp_overflow_o(b_sovf), .rsp_err_o(b_serr),
      .dp_op_o(b_dop), .dp_in1_o(b_din1), .dp_in2_o(b_din2), .dp_out_i(b_dout), .dp_overflow_i(b_dovf),
      .busy_o(b_busy)
   );

   // Call just after a negedge with inputs set; returns #1 later in the handshake cycle.
   task automatic wait_grant(output logic [1:0] g, output bit to);
      to = 1'b1;
      g  = 2'b00;
      for (int i = 0; i < 40; i++) begin
         #1;
         if ((rv & rrdy) != 2'b00) begin
            g  = rv & rrdy;
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output bit to);
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (sv != 2'b00) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rv  = 2'b11;
      rop[0] = MODE_ADD; ra[0] = 16'h3F80; rb[0] = 16'h4000;
      repeat (2) @(negedge clk);
      #1;
      total_n++; if ({rrdy, sv, busy, sovf, serr} !== 7'b0) $display("FAIL reset_ctrl: got %b want 0", {rrdy, sv, busy, sovf, serr}); else pass_n++;
      total_n++; if ({sdata, dop, din1, din2} !== '0) $display("FAIL reset_data: got %h want 0", {sdata, dop, din1, din2}); else pass_n++;
      total_n++; if ({b_rrdy, b_sv, b_busy} !== 5'b0) $display("FAIL reset_lat4: got %b want 0", {b_rrdy, b_sv, b_busy}); else pass_n++;
      rv = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_add();
      exp_t e;
      rv = 2'b01; rop[0] = MODE_ADD; ra[0] = 16'h3F80; rb[0] = 16'h4000;
      #1;
      total_n++; if (rrdy !== 2'b01) $display("FAIL add_grant: got %b want 01", rrdy); else pass_n++;
      sb.push_back(expect_rsp(2'b01, MODE_ADD, 16'h3F80, 16'h4000));
      @(negedge clk);
      rv = 2'b00;
      #1;
      total_n++; if ({busy, rrdy, sv} !== 5'b1_00_00) $display("FAIL add_exec_ctrl: got %b want 10000", {busy, rrdy, sv}); else pass_n++;
      total_n++; if ({dop, din1, din2} !== {MODE_ADD, 16'h3F80, 16'h4000}) $display("FAIL add_dp_drive: got %h want %h", {dop, din1, din2}, {MODE_ADD, 16'h3F80, 16'h4000}); else pass_n++;
      @(negedge clk);
      #1;
      total_n++; if (sv !== 2'b01) $display("FAIL add_latency: got %b want 01", sv); else pass_n++;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total_n++; if ({sv, sdata, sovf, serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL add_rsp: got %h want %h", {sv, sdata, sovf, serr}, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
      end
      total_n++; if (din1 !== 16'h3F80) $display("FAIL add_dp_hold: got %h want 3f80", din1); else pass_n++;
      srdy = 2'b01;
      @(negedge clk);
      srdy = 2'b00;
      #1;
      total_n++; if ({busy, sv, dop, din1, din2} !== '0) $display("FAIL add_idle: got %h want 0", {busy, sv, dop, din1, din2}); else pass_n++;
   endtask

   task automatic test_both_same_cycle();
      exp_t e;
      logic [1:0] g;
      bit to;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rv = 2'b11;
      for (int r = 0; r < 2; r++) begin
         rop[r] = MODE_MUL; ra[r] = 16'h4000; rb[r] = 16'h4000;
      end
      sb.push_back(expect_rsp(2'b01, MODE_MUL, 16'h4000, 16'h4000));
      sb.push_back(expect_rsp(2'b10, MODE_MUL, 16'h4000, 16'h4000));
      for (int k = 0; k < 2; k++) begin
         wait_grant(g, to);
         total_n++; if (to || g !== (k == 0 ? 2'b01 : 2'b10)) $display("FAIL both_grant%0d: got %b timeout %0d want %b", k, g, to, (k == 0 ? 2'b01 : 2'b10)); else pass_n++;
         @(negedge clk);
         rv = rv & ~g;
         wait_rsp(to);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total_n++; if (to || {sv, sdata, sovf, serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL both_rsp%0d: got %h timeout %0d want %h", k, {sv, sdata, sovf, serr}, to, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
         end
         srdy = sv;
         @(negedge clk);
         srdy = 2'b00;
      end
      rv = 2'b00;
   endtask

   task automatic test_rr_alternate();
      exp_t e;
      logic [1:0] g;
      bit to;
      int last;
      last = 0;
      rv = 2'b11;
      rop[0] = MODE_ADD; ra[0] = 16'h3F80; rb[0] = 16'h3F80;
      rop[1] = MODE_MUL; ra[1] = 16'h3F80; rb[1] = 16'h4040;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g, to);
         total_n++; if (to || g !== ((k % 2) ? 2'b10 : 2'b01)) $display("FAIL rr_grant%0d: got %b timeout %0d want %b", k, g, to, ((k % 2) ? 2'b10 : 2'b01)); else pass_n++;
         if (k > 0) begin
            total_n++; if (cyc - last != 3) $display("FAIL rr_spacing%0d: got %0d want 3", k, cyc - last); else pass_n++;
         end
         last = cyc;
         sb.push_back(expect_rsp(g, rop[g[1]], ra[g[1]], rb[g[1]]));
         @(negedge clk);
         wait_rsp(to);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total_n++; if (to || {sv, sdata, sovf, serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL rr_rsp%0d: got %h timeout %0d want %h", k, {sv, sdata, sovf, serr}, to, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
         end
         srdy = sv;
         @(negedge clk);
         srdy = 2'b00;
         if (k == 3) rv = 2'b00;
      end
   endtask

   task automatic test_stall();
      exp_t e;
      logic [1:0] g;
      bit to;
      rv = 2'b10; rop[1] = MODE_MUL; ra[1] = 16'h7F00; rb[1] = 16'h7F00;
      wait_grant(g, to);
      total_n++; if (to || g !== 2'b10) $display("FAIL stall_grant: got %b timeout %0d want 10", g, to); else pass_n++;
      sb.push_back(expect_rsp(2'b10, MODE_MUL, 16'h7F00, 16'h7F00));
      @(negedge clk);
      // requester 0 waits while requester 1's result is held; its ready must be ignored
      rv = 2'b01; rop[0] = MODE_ADD; ra[0] = 16'h3F80; rb[0] = 16'h4000;
      srdy = 2'b01;
      wait_rsp(to);
      e = '{2'b00, 16'h0000, 1'b0, 1'b0};
      if (sb.size() > 0) e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         total_n++; if (to || {sv, sdata, sovf, serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL stall_rsp%0d: got %h want %h", c, {sv, sdata, sovf, serr}, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
         total_n++; if ({rrdy, busy} !== 3'b00_1) $display("FAIL stall_ctrl%0d: got %b want 001", c, {rrdy, busy}); else pass_n++;
         @(negedge clk);
         #1;
      end
      srdy = 2'b10;
      @(negedge clk);
      srdy = 2'b00;
      wait_grant(g, to);
      total_n++; if (to || g !== 2'b01) $display("FAIL stall_next_grant: got %b timeout %0d want 01", g, to); else pass_n++;
      sb.push_back(expect_rsp(2'b01, MODE_ADD, 16'h3F80, 16'h4000));
      @(negedge clk);
      rv = 2'b00;
      wait_rsp(to);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total_n++; if (to || {sv, sdata, sovf, serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL stall_next_rsp: got %h want %h", {sv, sdata, sovf, serr}, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
      end
      srdy = sv;
      @(negedge clk);
      srdy = 2'b00;
   endtask

   task automatic test_illegal();
      exp_t e;
      logic [1:0] g;
      bit to;
      rv = 2'b10; rop[1] = 2'd3; ra[1] = 16'h1234; rb[1] = 16'h5678;
      wait_grant(g, to);
      total_n++; if (to || g !== 2'b10) $display("FAIL ill_grant: got %b timeout %0d want 10", g, to); else pass_n++;
      sb.push_back(expect_rsp(2'b10, 2'd3, 16'h1234, 16'h5678));
      @(negedge clk);
      rv = 2'b00;
      wait_rsp(to);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total_n++; if (to || {sv, sdata, sovf, serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL ill_rsp: got %h want %h", {sv, sdata, sovf, serr}, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
      end
      srdy = 2'b11;
      @(negedge clk);
      srdy = 2'b00;
   endtask

   task automatic test_reset_mid_exec();
      exp_t e;
      bit seen;
      b_rv = 2'b01; b_rop[0] = MODE_ADD; b_ra[0] = 16'h3F80; b_rb[0] = 16'h4000;
      #1;
      total_n++; if (b_rrdy !== 2'b01) $display("FAIL rst4_grant: got %b want 01", b_rrdy); else pass_n++;
      @(negedge clk);
      b_rv = 2'b00;
      @(negedge clk);
      #1;
      total_n++; if ({b_busy, b_sv} !== 3'b1_00) $display("FAIL rst4_exec: got %b want 100", {b_busy, b_sv}); else pass_n++;
      rst = 1'b1;
      #1;
      total_n++; if ({b_rrdy, b_sv, b_busy, b_sovf, b_serr} !== 7'b0) $display("FAIL rst4_ctrl: got %b want 0", {b_rrdy, b_sv, b_busy, b_sovf, b_serr}); else pass_n++;
      total_n++; if ({b_sdata, b_dop, b_din1, b_din2} !== '0) $display("FAIL rst4_data: got %h want 0", {b_sdata, b_dop, b_din1, b_din2}); else pass_n++;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (b_sv != 2'b00 || b_busy) seen = 1'b1;
      end
      total_n++; if (seen !== 1'b0) $display("FAIL rst4_dropped: got activity %0d want 0", seen); else pass_n++;
      b_rv = 2'b01;
      #1;
      total_n++; if (b_rrdy !== 2'b01) $display("FAIL rst4_regrant: got %b want 01", b_rrdy); else pass_n++;
      sb.push_back(expect_rsp(2'b01, MODE_ADD, 16'h3F80, 16'h4000));
      @(negedge clk);
      b_rv = 2'b00;
      repeat (4) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total_n++; if ({b_sv, b_sdata, b_sovf, b_serr} !== {e.idx, e.data, e.ovf, e.err}) $display("FAIL rst4_rsp: got %h want %h", {b_sv, b_sdata, b_sovf, b_serr}, {e.idx, e.data, e.ovf, e.err}); else pass_n++;
      end
      b_srdy = 2'b01;
      @(negedge clk);
      b_srdy = 2'b00;
      #1;
      total_n++; if (b_busy !== 1'b0) $display("FAIL rst4_done: got %b want 0", b_busy); else pass_n++;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_both_same_cycle();
      test_rr_alternate();
      test_stall();
      test_illegal();
      test_reset_mid_exec();
      total_n++; if (sb.size() != 0) $display("FAIL sb_empty: got %0d want 0", sb.size()); else pass_n++;
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
